cpu_fetch_sequencer: RTL and testbench
======================================

# cpu_fetch_sequencer

Control FSM that sequences the CPU's register latches (PC, MAR, MDR, IR) through the fetch/execute cycle. It drives the per-latch `load`/`inc`/clear strobes and handshakes with memory (`mem_req`/`mem_ack`) and the execute unit (`exec_start`/`exec_done`). It sits between the top-level run control and the datapath latches, and is the only block permitted to drive their strobes.

## Interface
- `N`, 8: width of `instr_count`.
- `TIMEOUT`, 15: maximum memory wait cycles before fault; must be 1..255.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset. **One clock; reset is asynchronous and active-low.**
- `run` in 1: level; start/resume execution.
- `halt_req` in 1: level; stop at the next instruction boundary.
- `mem_ack` in 1: memory read data valid on MDR input this cycle.
- `exec_done` in 1: execute unit finished the current instruction.
- `exec_jump` in 1: qualified by `exec_done`; PC must be reloaded.
- `exec_halt` in 1: qualified by `exec_done`; instruction is HALT.
- `latch_clr` out 1: clear PC/MAR/MDR/IR.
- `pc_load`, `pc_inc`, `mar_load`, `mdr_load`, `ir_load` out 1: latch strobes.
- `mem_req` out 1: memory read request.
- `exec_start` out 1: one-cycle pulse; start execute.
- `busy` out 1: high in every state except IDLE, HALTED and FAULT.
- `halted` out 1: high in HALTED.
- `fault` out 1: high in FAULT.
- `state` out 4: current state encoding.
- `instr_count` out N: completed-instruction counter.

## Operation
- Moore FSM. Every strobe is decoded from the registered state only. Encodings:
  - IDLE=0, CLEAR=1, ADDR=2, MEM=3, DATA=4, IR=5, EXEC=6, JUMP=7, HALTED=8, FAULT=9. Unused encodings go to IDLE.
- IDLE: all strobes low. `run`=1 → CLEAR.
- CLEAR: `latch_clr`=1 → ADDR.
- ADDR: `mar_load`=1 → MEM.
- MEM: `mem_req`=1. `mem_ack`=1 → DATA. Timeout → FAULT. Otherwise stay.
- DATA: `mdr_load`=1 and `pc_inc`=1 → IR.
- IR: `ir_load`=1 → EXEC.
- EXEC: `exec_start`=1 on the first EXEC cycle only. Wait for `exec_done`. On `exec_done`, `instr_count` increments (wraps 2^N−1 → 0). Priority on `exec_done`:
  1. `exec_halt`=1 or `halt_req`=1 → HALTED.
  2. `exec_jump`=1 → JUMP.
  3. Otherwise → ADDR.
- JUMP: `pc_load`=1 → ADDR. If `halt_req` is high here, still go to ADDR; the halt is taken at the next `exec_done`.
- HALTED: `run`=1 and `halt_req`=0 → ADDR. Latches are not cleared on resume.
- FAULT: sticky; exits only on reset.
- `run`=0 is checked only in IDLE and HALTED; dropping it mid-instruction has no effect.
- Invariants:
  - `pc_load` and `pc_inc` are never high together; a latch given load and inc together holds its value.
  - At most one of `mar_load`, `mdr_load`, `ir_load`, `pc_load` is high per cycle, except `pc_inc` with `mdr_load` in DATA.
  - `mem_ack` outside MEM and `exec_done` outside EXEC are ignored.

## Timing
- Reset (async assert, sync release) sets: state=IDLE, all strobes=0, `busy`=0, `halted`=0, `fault`=0, `instr_count`=0, timeout counter=0.
- `run` sampled high at edge k: CLEAR during cycle k+1, ADDR k+2, first `mem_req` at k+3.
- Zero-wait memory plus `exec_done` in the first EXEC cycle gives a 5-cycle instruction (ADDR, MEM, DATA, IR, EXEC). A taken jump adds 1 cycle (JUMP).
- Each cycle `mem_ack` is late adds one MEM cycle.
- `exec_done` in the same cycle as the `exec_start` pulse is legal.
- Timeout counter clears on MEM entry and increments on each MEM cycle without `mem_ack`. When the count reaches `TIMEOUT` without ack → FAULT. `mem_ack` on the cycle the count reaches `TIMEOUT` wins (→ DATA).
- Reset mid-instruction drops all strobes immediately (asynchronously).

## Configuration
- `CPU_SEQ_TIMEOUT_EN` defined: timeout counter and the MEM→FAULT transition are present; `fault` can assert.
- Not defined: no counter is built; MEM waits indefinitely for `mem_ack`; `fault` is tied 0 and FAULT is unreachable.

## Test plan
- Reset then `run`=1, `mem_ack` tied 1, `exec_done` returned in the first EXEC cycle → state sequence 1,2,3,4,5,6,2…; `instr_count`=3 after 3 instructions; `pc_inc` high exactly once per instruction.
- `exec_done` with `exec_jump`=1 → exactly one `pc_load` cycle in JUMP, `pc_inc` never high in the same cycle; next state ADDR.
- `mem_ack` delayed 4 cycles → 5 MEM cycles with `mem_req` held high, then DATA; `fault`=0.
- With macro and `TIMEOUT`=15, `mem_ack` never asserted → FAULT after 15 MEM cycles; `fault`=1 and `busy`=0, held through `run` toggles until reset.
- `halt_req`=1 during EXEC → HALTED after `exec_done`, `halted`=1. Then `halt_req`=0 with `run`=1 → ADDR without `latch_clr`.
- Reset asserted in DATA → strobes low within the same cycle, state=0, `instr_count`=0. Also check `instr_count` with `N`=2 wraps 3→0.

Source files
------------

// File: rtl/cpu_fetch_sequencer.sv
// cpu_fetch_sequencer: Moore control FSM that steps the PC/MAR/MDR/IR latches
// through fetch/execute, handshaking with memory and the execute unit.
// Optional feature macro: CPU_SEQ_TIMEOUT_EN enables the memory-wait timeout
// counter and the MEM->FAULT transition; without it MEM waits indefinitely.
// Strobes are registered from the next state, so each one is high exactly
// during the cycles its state is held, and reset clears them asynchronously.

module cpu_fetch_sequencer #(
  parameter int unsigned N       = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  input  logic         halt_req,
  input  logic         mem_ack,
  input  logic         exec_done,
  input  logic         exec_jump,
  input  logic         exec_halt,
  output logic         latch_clr,
  output logic         pc_load,
  output logic         pc_inc,
  output logic         mar_load,
  output logic         mdr_load,
  output logic         ir_load,
  output logic         mem_req,
  output logic         exec_start,
  output logic         busy,
  output logic         halted,
  output logic         fault,
  output logic [3:0]   state,
  output logic [N-1:0] instr_count
);

  localparam int unsigned STATE_W = 4;
  localparam int unsigned TMO_W   = 8;

  // Reject timeout values the 8-bit wait counter cannot represent.
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("cpu_fetch_sequencer: TIMEOUT must be 1..255");
  end

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 4'd0,
    S_CLEAR  = 4'd1,
    S_ADDR   = 4'd2,
    S_MEM    = 4'd3,
    S_DATA   = 4'd4,
    S_IR     = 4'd5,
    S_EXEC   = 4'd6,
    S_JUMP   = 4'd7,
    S_HALTED = 4'd8,
    S_FAULT  = 4'd9
  } state_e;

  state_e cur;
  state_e nxt;
  logic   tmo_expired;

`ifdef CPU_SEQ_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;

  // Final unacknowledged MEM cycle: the count would reach TIMEOUT this cycle.
  assign tmo_expired = (cur == S_MEM) && (tmo_cnt == TMO_W'(TIMEOUT - 1));

  // Memory wait counter: cleared on MEM entry, counts MEM cycles without ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if (nxt == S_MEM && cur != S_MEM) begin
      tmo_cnt <= '0;
    end else if (cur == S_MEM && !mem_ack) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  // Fault flag, sticky with the FAULT state until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault <= 1'b0;
    end else begin
      fault <= (nxt == S_FAULT);
    end
  end
`else
  assign tmo_expired = 1'b0;
  assign fault       = 1'b0;
`endif

  // Next-state decode; ack beats timeout, halt beats jump on exec_done.
  always_comb begin
    nxt = S_IDLE;
    case (cur)
      S_IDLE:   nxt = run ? S_CLEAR : S_IDLE;
      S_CLEAR:  nxt = S_ADDR;
      S_ADDR:   nxt = S_MEM;
      S_MEM: begin
        nxt = S_MEM;
        if (tmo_expired) nxt = S_FAULT;
        if (mem_ack)     nxt = S_DATA;
      end
      S_DATA:   nxt = S_IR;
      S_IR:     nxt = S_EXEC;
      S_EXEC: begin
        nxt = S_EXEC;
        if (exec_done) begin
          if (exec_halt || halt_req) nxt = S_HALTED;
          else if (exec_jump)        nxt = S_JUMP;
          else                       nxt = S_ADDR;
        end
      end
      S_JUMP:   nxt = S_ADDR;
      S_HALTED: nxt = (run && !halt_req) ? S_ADDR : S_HALTED;
      S_FAULT:  nxt = S_FAULT;
      default:  nxt = S_IDLE;
    endcase
  end

  // State register plus strobes and status flags registered from next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur        <= S_IDLE;
      latch_clr  <= 1'b0;
      pc_load    <= 1'b0;
      pc_inc     <= 1'b0;
      mar_load   <= 1'b0;
      mdr_load   <= 1'b0;
      ir_load    <= 1'b0;
      mem_req    <= 1'b0;
      exec_start <= 1'b0;
      busy       <= 1'b0;
      halted     <= 1'b0;
    end else begin
      cur        <= nxt;
      latch_clr  <= (nxt == S_CLEAR);
      pc_load    <= (nxt == S_JUMP);
      pc_inc     <= (nxt == S_DATA);
      mar_load   <= (nxt == S_ADDR);
      mdr_load   <= (nxt == S_DATA);
      ir_load    <= (nxt == S_IR);
      mem_req    <= (nxt == S_MEM);
      exec_start <= (nxt == S_EXEC) && (cur != S_EXEC);
      busy       <= !((nxt == S_IDLE) || (nxt == S_HALTED) || (nxt == S_FAULT));
      halted     <= (nxt == S_HALTED);
    end
  end

  // Completed-instruction counter; wraps naturally at 2^N.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_count <= '0;
    end else if (cur == S_EXEC && exec_done) begin
      instr_count <= instr_count + N'(1);
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_cpu_fetch_sequencer.sv
// Directed bench for cpu_fetch_sequencer; a second instance with N=2 shares
// all inputs and is used to observe instr_count wrap.

module tb_cpu_fetch_sequencer;

  logic clk;
  logic rst;
  logic run, halt_req, mem_ack, exec_done, exec_jump, exec_halt;

  logic latch_clr, pc_load, pc_inc, mar_load, mdr_load, ir_load;
  logic mem_req, exec_start, busy, halted, fault;
  logic [3:0] state;
  logic [7:0] instr_count;

  logic w_latch_clr, w_pc_load, w_pc_inc, w_mar_load, w_mdr_load, w_ir_load;
  logic w_mem_req, w_exec_start, w_busy, w_halted, w_fault;
  logic [3:0] w_state;
  logic [1:0] w_instr_count;

  int checks;
  int failures;

  cpu_fetch_sequencer #(.N(8), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .run(run), .halt_req(halt_req), .mem_ack(mem_ack),
    .exec_done(exec_done), .exec_jump(exec_jump), .exec_halt(exec_halt),
    .latch_clr(latch_clr), .pc_load(pc_load), .pc_inc(pc_inc),
    .mar_load(mar_load), .mdr_load(mdr_load), .ir_load(ir_load),
    .mem_req(mem_req), .exec_start(exec_start), .busy(busy),
    .halted(halted), .fault(fault), .state(state), .instr_count(instr_count)
  );

  cpu_fetch_sequencer #(.N(2), .TIMEOUT(15)) dut2 (
    .clk(clk), .rst(rst), .run(run), .halt_req(halt_req), .mem_ack(mem_ack),
    .exec_done(exec_done), .exec_jump(exec_jump), .exec_halt(exec_halt),
    .latch_clr(w_latch_clr), .pc_load(w_pc_load), .pc_inc(w_pc_inc),
    .mar_load(w_mar_load), .mdr_load(w_mdr_load), .ir_load(w_ir_load),
    .mem_req(w_mem_req), .exec_start(w_exec_start), .busy(w_busy),
    .halted(w_halted), .fault(w_fault), .state(w_state),
    .instr_count(w_instr_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Observed outputs packed {latch_clr,pc_load,pc_inc,mar_load,mdr_load,
  // ir_load,mem_req,exec_start,busy,halted,fault}.
  function automatic logic [10:0] act_vec();
    return {latch_clr, pc_load, pc_inc, mar_load, mdr_load, ir_load,
            mem_req, exec_start, busy, halted, fault};
  endfunction

  // Expected outputs for a state, assuming single-cycle EXEC visits.
  function automatic logic [10:0] exp_vec(input int s);
    logic [10:0] v;
    v = '0;
    case (s)
      1: v[10] = 1'b1;
      2: v[7]  = 1'b1;
      3: v[4]  = 1'b1;
      4: begin v[6] = 1'b1; v[8] = 1'b1; end
      5: v[5]  = 1'b1;
      6: v[3]  = 1'b1;
      7: v[9]  = 1'b1;
      8: v[1]  = 1'b1;
      9: v[0]  = 1'b1;
      default: v = '0;
    endcase
    if (s >= 1 && s <= 7) v[2] = 1'b1;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; run = 1'b0; halt_req = 1'b0; mem_ack = 1'b0;
    exec_done = 1'b0; exec_jump = 1'b0; exec_halt = 1'b0;
    step(); step();
    checks++;
    if (state !== 4'd0) begin
      failures++; $display("FAIL reset_state got=%0d exp=0", state);
    end
    checks++;
    if (act_vec() !== 11'd0) begin
      failures++; $display("FAIL reset_outputs got=%b exp=%b", act_vec(), 11'd0);
    end
    checks++;
    if (instr_count !== 8'd0 || w_instr_count !== 2'd0) begin
      failures++; $display("FAIL reset_count got=%0d/%0d exp=0/0", instr_count, w_instr_count);
    end
    rst = 1'b1;
    step();
    checks++;
    if (state !== 4'd0) begin
      failures++; $display("FAIL idle_without_run got=%0d exp=0", state);
    end
  endtask

  task automatic test_basic();
    int seq [17] = '{1,2,3,4,5,6,2,3,4,5,6,2,3,4,5,6,2};
    int incs;
    incs = 0;
    mem_ack = 1'b1; exec_done = 1'b1; run = 1'b1;
    for (int i = 0; i < 17; i++) begin
      step();
      if (pc_inc === 1'b1) incs++;
      checks++;
      if (state !== 4'(seq[i])) begin
        failures++; $display("FAIL basic_state[%0d] got=%0d exp=%0d", i, state, seq[i]);
      end
      checks++;
      if (act_vec() !== exp_vec(seq[i])) begin
        failures++; $display("FAIL basic_outputs[%0d] got=%b exp=%b", i, act_vec(), exp_vec(seq[i]));
      end
    end
    checks++;
    if (incs != 3) begin
      failures++; $display("FAIL basic_pc_inc_count got=%0d exp=3", incs);
    end
    checks++;
    if (instr_count !== 8'd3 || w_instr_count !== 2'd3) begin
      failures++; $display("FAIL basic_instr_count got=%0d/%0d exp=3/3", instr_count, w_instr_count);
    end
  endtask

  task automatic test_jump();
    int seq [6] = '{3,4,5,6,7,2};
    int loads;
    loads = 0;
    exec_jump = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (pc_load === 1'b1) loads++;
      checks++;
      if (state !== 4'(seq[i])) begin
        failures++; $display("FAIL jump_state[%0d] got=%0d exp=%0d", i, state, seq[i]);
      end
      checks++;
      if (act_vec() !== exp_vec(seq[i])) begin
        failures++; $display("FAIL jump_outputs[%0d] got=%b exp=%b", i, act_vec(), exp_vec(seq[i]));
      end
    end
    exec_jump = 1'b0;
    checks++;
    if (loads != 1) begin
      failures++; $display("FAIL jump_pc_load_count got=%0d exp=1", loads);
    end
    checks++;
    if (instr_count !== 8'd4 || w_instr_count !== 2'd0) begin
      failures++; $display("FAIL jump_count_wrap got=%0d/%0d exp=4/0", instr_count, w_instr_count);
    end
  endtask

  task automatic test_mem_wait();
    int seq [9] = '{3,3,3,3,3,4,5,6,2};
    mem_ack = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step();
      checks++;
      if (state !== 4'(seq[i])) begin
        failures++; $display("FAIL wait_state[%0d] got=%0d exp=%0d", i, state, seq[i]);
      end
      checks++;
      if (act_vec() !== exp_vec(seq[i])) begin
        failures++; $display("FAIL wait_outputs[%0d] got=%b exp=%b", i, act_vec(), exp_vec(seq[i]));
      end
      mem_ack = (i >= 4);
    end
    checks++;
    if (instr_count !== 8'd5 || w_instr_count !== 2'd1) begin
      failures++; $display("FAIL wait_instr_count got=%0d/%0d exp=5/1", instr_count, w_instr_count);
    end
  endtask

  task automatic test_halt();
    int seq [5] = '{3,4,5,6,8};
    halt_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (state !== 4'(seq[i]) || act_vec() !== exp_vec(seq[i])) begin
        failures++; $display("FAIL halt_req_seq[%0d] got=%0d/%b exp=%0d/%b", i, state, act_vec(), seq[i], exp_vec(seq[i]));
      end
    end
    halt_req = 1'b0; run = 1'b0;
    step(); step();
    checks++;
    if (state !== 4'd8 || halted !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL halt_hold got=%0d/%b/%b exp=8/1/0", state, halted, busy);
    end
    run = 1'b1;
    step();
    checks++;
    if (state !== 4'd2 || latch_clr !== 1'b0 || halted !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL halt_resume got=%0d/%b/%b/%b exp=2/0/0/1", state, latch_clr, halted, busy);
    end
    exec_halt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (state !== 4'(seq[i]) || act_vec() !== exp_vec(seq[i])) begin
        failures++; $display("FAIL exec_halt_seq[%0d] got=%0d/%b exp=%0d/%b", i, state, act_vec(), seq[i], exp_vec(seq[i]));
      end
    end
    exec_halt = 1'b0;
    checks++;
    if (instr_count !== 8'd7 || w_instr_count !== 2'd3) begin
      failures++; $display("FAIL halt_instr_count got=%0d/%0d exp=7/3", instr_count, w_instr_count);
    end
    step();
    checks++;
    if (state !== 4'd2) begin
      failures++; $display("FAIL exec_halt_resume got=%0d exp=2", state);
    end
  endtask

  task automatic test_reset_mid();
    step(); step();
    checks++;
    if (state !== 4'd4 || mdr_load !== 1'b1 || pc_inc !== 1'b1 || pc_load !== 1'b0) begin
      failures++; $display("FAIL data_strobes got=%0d/%b%b%b exp=4/110", state, mdr_load, pc_inc, pc_load);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || act_vec() !== 11'd0) begin
      failures++; $display("FAIL async_reset got=%0d/%b exp=0/%b", state, act_vec(), 11'd0);
    end
    checks++;
    if (instr_count !== 8'd0 || w_instr_count !== 2'd0) begin
      failures++; $display("FAIL async_reset_count got=%0d/%0d exp=0/0", instr_count, w_instr_count);
    end
    run = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic test_timeout();
    mem_ack = 1'b0; run = 1'b1;
    step();
    step();
    checks++;
    if (state !== 4'd2) begin
      failures++; $display("FAIL tmo_pre_state got=%0d exp=2", state);
    end
`ifdef CPU_SEQ_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      step();
      checks++;
      if (state !== 4'd3 || mem_req !== 1'b1 || fault !== 1'b0) begin
        failures++; $display("FAIL tmo_mem[%0d] got=%0d/%b/%b exp=3/1/0", i, state, mem_req, fault);
      end
    end
    step();
    checks++;
    if (state !== 4'd9 || act_vec() !== exp_vec(9)) begin
      failures++; $display("FAIL tmo_fault got=%0d/%b exp=9/%b", state, act_vec(), exp_vec(9));
    end
    run = 1'b0; mem_ack = 1'b1;
    step();
    run = 1'b1;
    step(); step();
    checks++;
    if (state !== 4'd9 || fault !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL tmo_sticky got=%0d/%b/%b exp=9/1/0", state, fault, busy);
    end
`else
    for (int i = 0; i < 40; i++) begin
      step();
      checks++;
      if (state !== 4'd3 || mem_req !== 1'b1 || fault !== 1'b0) begin
        failures++; $display("FAIL no_tmo_mem[%0d] got=%0d/%b/%b exp=3/1/0", i, state, mem_req, fault);
      end
    end
    mem_ack = 1'b1;
    step();
    checks++;
    if (state !== 4'd4 || fault !== 1'b0) begin
      failures++; $display("FAIL no_tmo_data got=%0d/%b exp=4/0", state, fault);
    end
`endif
    rst = 1'b0; run = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || fault !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL tmo_reset got=%0d/%b/%b exp=0/0/0", state, fault, busy);
    end
    step();
    rst = 1'b1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_jump();
    test_mem_wait();
    test_halt();
    test_reset_mid();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
